// File: rtl/cas_pkg.sv
// Shared types and default widths for the compare-and-swap array.
package cas_pkg;

    localparam int CAS_DATAWIDTH = 8;
    localparam int CAS_IDXWIDTH  = 4;

    typedef enum logic {
        CAS_ASC  = 1'b0,
        CAS_DESC = 1'b1
    } cas_dir_e;

    // Key/tag record at the default widths; parametrised blocks declare a local twin.
    typedef struct packed {
        logic [CAS_DATAWIDTH-1:0] key;
        logic [CAS_IDXWIDTH-1:0]  idx;
    } cas_lane_t;

    typedef enum logic [1:0] {
        CAS_EMPTY = 2'd0,
        CAS_BUSY  = 2'd1,
        CAS_FULL  = 2'd2
    } cas_state_e;

endpackage

// File: rtl/cas_lane.sv
// One combinational compare-and-swap lane; the tag travels with its key.
module cas_lane
    import cas_pkg::*;
#(
    parameter int DATAWIDTH = CAS_DATAWIDTH,
    parameter int IDXWIDTH  = CAS_IDXWIDTH
) (
    input  logic [DATAWIDTH-1:0] x1,
    input  logic [DATAWIDTH-1:0] x2,
    input  logic [IDXWIDTH-1:0]  idx1,
    input  logic [IDXWIDTH-1:0]  idx2,
    input  cas_dir_e             dir,
    input  logic                 sign_ctrl,
    output logic [DATAWIDTH-1:0] y1,
    output logic [DATAWIDTH-1:0] y2,
    output logic [IDXWIDTH-1:0]  yidx1,
    output logic [IDXWIDTH-1:0]  yidx2,
    output logic                 swap
);

    typedef struct packed {
        logic [DATAWIDTH-1:0] key;
        logic [IDXWIDTH-1:0]  idx;
    } lane_t;

    logic  gt_s;
    logic  lt_s;
    logic  swap_s;
    lane_t a_s;
    lane_t b_s;
    lane_t first_s;
    lane_t second_s;

    assign a_s = '{key: x1, idx: idx1};
    assign b_s = '{key: x2, idx: idx2};

    // Magnitude relation under the selected number interpretation.
    always_comb begin
        gt_s = 1'b0;
        lt_s = 1'b0;
        if (sign_ctrl) begin
            gt_s = $signed(x1) > $signed(x2);
            lt_s = $signed(x1) < $signed(x2);
        end else begin
            gt_s = x1 > x2;
            lt_s = x1 < x2;
        end
    end

    // Strict comparisons keep equal keys in place.
    always_comb begin
        swap_s   = 1'b0;
        first_s  = a_s;
        second_s = b_s;
        case (dir)
            CAS_DESC: swap_s = lt_s;
            CAS_ASC:  swap_s = gt_s;
            default:  swap_s = 1'b0;
        endcase
        if (swap_s) begin
            first_s  = b_s;
            second_s = a_s;
        end else begin
            first_s  = a_s;
            second_s = b_s;
        end
    end

    assign y1    = first_s.key;
    assign y2    = second_s.key;
    assign yidx1 = first_s.idx;
    assign yidx2 = second_s.idx;
    assign swap  = swap_s;

endmodule

// File: rtl/cas_array_pipe.sv
// LANES compare-and-swap lanes behind a 2-entry skid buffer with valid/ready on both sides.
// Define CAS_ARRAY_SWAP_CNT_EN to enable the saturating swap statistics counter.
module cas_array_pipe
    import cas_pkg::*;
#(
    parameter int DATAWIDTH = CAS_DATAWIDTH,
    parameter int IDXWIDTH  = CAS_IDXWIDTH,
    parameter int LANES     = 4,
    parameter int CNTWIDTH  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic                      sign_ctrl_i,
    input  logic [LANES-1:0]          dir_i,
    input  logic [LANES*DATAWIDTH-1:0] x1_i,
    input  logic [LANES*DATAWIDTH-1:0] x2_i,
    input  logic [LANES*IDXWIDTH-1:0]  idx1_i,
    input  logic [LANES*IDXWIDTH-1:0]  idx2_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [LANES*DATAWIDTH-1:0] y1_o,
    output logic [LANES*DATAWIDTH-1:0] y2_o,
    output logic [LANES*IDXWIDTH-1:0]  yidx1_o,
    output logic [LANES*IDXWIDTH-1:0]  yidx2_o,
    output logic [LANES-1:0]          swap_o,
    output logic [CNTWIDTH-1:0]       swap_cnt_o
);

    localparam int KW = LANES * DATAWIDTH;
    localparam int TW = LANES * IDXWIDTH;
    localparam int BW = 2 * KW + 2 * TW + LANES;

    logic [KW-1:0]    cmp_y1_s;
    logic [KW-1:0]    cmp_y2_s;
    logic [TW-1:0]    cmp_yidx1_s;
    logic [TW-1:0]    cmp_yidx2_s;
    logic [LANES-1:0] cmp_swap_s;
    logic [BW-1:0]    beat_in_s;

    logic [BW-1:0]    main_r;
    logic [BW-1:0]    skid_r;
    logic [BW-1:0]    main_nxt_s;
    logic [BW-1:0]    skid_nxt_s;
    cas_state_e       state_r;
    cas_state_e       state_nxt_s;
    logic             ready_r;
    logic             valid_r;
    logic             accept_s;

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        cas_lane #(
            .DATAWIDTH(DATAWIDTH),
            .IDXWIDTH (IDXWIDTH)
        ) u_lane (
            .x1       (x1_i[n*DATAWIDTH +: DATAWIDTH]),
            .x2       (x2_i[n*DATAWIDTH +: DATAWIDTH]),
            .idx1     (idx1_i[n*IDXWIDTH +: IDXWIDTH]),
            .idx2     (idx2_i[n*IDXWIDTH +: IDXWIDTH]),
            .dir      (cas_dir_e'(dir_i[n])),
            .sign_ctrl(sign_ctrl_i),
            .y1       (cmp_y1_s[n*DATAWIDTH +: DATAWIDTH]),
            .y2       (cmp_y2_s[n*DATAWIDTH +: DATAWIDTH]),
            .yidx1    (cmp_yidx1_s[n*IDXWIDTH +: IDXWIDTH]),
            .yidx2    (cmp_yidx2_s[n*IDXWIDTH +: IDXWIDTH]),
            .swap     (cmp_swap_s[n])
        );
    end

    assign beat_in_s = {cmp_y1_s, cmp_y2_s, cmp_yidx1_s, cmp_yidx2_s, cmp_swap_s};
    assign accept_s  = valid_i & ready_r;

    // Skid-buffer next state: M always holds the oldest beat, S only fills on a stalled accept.
    always_comb begin
        state_nxt_s = state_r;
        main_nxt_s  = main_r;
        skid_nxt_s  = skid_r;
        case (state_r)
            CAS_EMPTY: begin
                if (accept_s) begin
                    state_nxt_s = CAS_BUSY;
                    main_nxt_s  = beat_in_s;
                end else begin
                    state_nxt_s = CAS_EMPTY;
                end
            end
            CAS_BUSY: begin
                if (accept_s && ready_i) begin
                    main_nxt_s = beat_in_s;
                end else if (accept_s) begin
                    state_nxt_s = CAS_FULL;
                    skid_nxt_s  = beat_in_s;
                end else if (ready_i) begin
                    state_nxt_s = CAS_EMPTY;
                end else begin
                    state_nxt_s = CAS_BUSY;
                end
            end
            CAS_FULL: begin
                if (ready_i) begin
                    state_nxt_s = CAS_BUSY;
                    main_nxt_s  = skid_r;
                end else begin
                    state_nxt_s = CAS_FULL;
                end
            end
            default: begin
                state_nxt_s = CAS_EMPTY;
            end
        endcase
    end

    // State, storage and handshake registers; ready is precomputed from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= CAS_EMPTY;
            main_r  <= {BW{1'b0}};
            skid_r  <= {BW{1'b0}};
            ready_r <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            main_r  <= main_nxt_s;
            skid_r  <= skid_nxt_s;
            ready_r <= (state_nxt_s != CAS_FULL);
            valid_r <= (state_nxt_s != CAS_EMPTY);
        end
    end

    assign ready_o = ready_r;
    assign valid_o = valid_r;
    assign {y1_o, y2_o, yidx1_o, yidx2_o, swap_o} = main_r;

`ifdef CAS_ARRAY_SWAP_CNT_EN
    localparam int PCW = $clog2(LANES + 1);

    function automatic logic [PCW-1:0] popcount(input logic [LANES-1:0] v);
        logic [PCW-1:0] c;
        c = {PCW{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            c = c + PCW'(v[i]);
        end
        return c;
    endfunction

    logic [CNTWIDTH-1:0] cnt_r;
    logic [CNTWIDTH:0]   cnt_sum_s;

    assign cnt_sum_s = {1'b0, cnt_r} + (CNTWIDTH + 1)'(popcount(cmp_swap_s));

    // Saturating accumulation of swapped lanes, counted on the accept edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= {CNTWIDTH{1'b0}};
        end else if (accept_s) begin
            cnt_r <= cnt_sum_s[CNTWIDTH] ? {CNTWIDTH{1'b1}} : cnt_sum_s[CNTWIDTH-1:0];
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign swap_cnt_o = cnt_r;
`else
    assign swap_cnt_o = {CNTWIDTH{1'b0}};
`endif

endmodule
